ref_win_fetch: RTL and testbench

- Read-side initiator for the behavioural reference-frame memory, which returns 64-bit data (8 bytes, big-endian, byte at addr in [63:56]) combinationally from en/addr.
- On start, walks a rectangular search window of the reference frame row by row in 8-byte words and drives the memory en/addr.
- Registers each returned word and presents it as a valid/ready stream to the ME search core, tagged with row/column and last flag.
- Sits between ref memory and the SAD/search datapath.

---
 rtl/ref_win_fetch_if.sv | 26 ++
 rtl/ref_win_fetch.sv | 144 ++++++++++++++
 tb/tb_ref_win_fetch.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/ref_win_fetch_if.sv
// Bundles the reference-memory read port and the pixel-word stream
// between the window fetcher and its neighbours.
interface ref_win_fetch_if #(
    parameter int WIN_W = 32,
    parameter int WIN_H = 4
);
    logic                        mem_en;
    logic [31:0]                 mem_addr;
    logic [63:0]                 mem_data;
    logic                        pix_valid;
    logic                        pix_ready;
    logic [63:0]                 pix_data;
    logic [$clog2(WIN_H):0]      pix_row;
    logic [$clog2(WIN_W/8):0]    pix_col;
    logic                        pix_last;

    modport master (
        output mem_en, mem_addr, pix_valid, pix_data, pix_row, pix_col, pix_last,
        input  mem_data, pix_ready
    );

    modport slave (
        input  mem_en, mem_addr, pix_valid, pix_data, pix_row, pix_col, pix_last,
        output mem_data, pix_ready
    );
endinterface

// File: rtl/ref_win_fetch.sv
// Walks a WIN_W x WIN_H byte window of the reference frame in 8-byte words
// and streams the returned words downstream with row/column/last tags.
module ref_win_fetch #(
    parameter logic [31:0] FRAME_BASE  = 32'd0,
    parameter int          FRAME_WIDTH = 1920,
    parameter int          WIN_W       = 32,
    parameter int          WIN_H       = 4,
    parameter int          COORD_W     = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COORD_W-1:0] base_x,
    input  logic [COORD_W-1:0] base_y,
    output logic               busy,
    output logic               done,
    ref_win_fetch_if.master    bus
);
    localparam int WORDS = WIN_W / 8;
    localparam int ROW_W = $clog2(WIN_H) + 1;
    localparam int COL_W = $clog2(WORDS) + 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(WIN_H - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WORDS - 1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t             state;
    logic [COORD_W-1:0] bx_q;
    logic [COORD_W-1:0] by_q;
    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row_nxt;
    logic [COL_W-1:0]   col_nxt;
    logic               mem_en_q;
    logic [31:0]        mem_addr_q;
    logic               pix_valid_q;
    logic [63:0]        pix_data_q;
    logic [ROW_W-1:0]   pix_row_q;
    logic [COL_W-1:0]   pix_col_q;
    logic               pix_last_q;
    logic               busy_q;
    logic               done_q;
    logic               adv;
    logic               hs;
    logic               last_issue;

    // All address arithmetic is 32-bit and wraps; the caller keeps the window inside the frame.
    function automatic logic [31:0] word_addr(input logic [COORD_W-1:0] by,
                                              input logic [COORD_W-1:0] bx,
                                              input logic [ROW_W-1:0]   r,
                                              input logic [COL_W-1:0]   c);
        return FRAME_BASE + (32'(by) + 32'(r)) * 32'(FRAME_WIDTH) + 32'(bx) + (32'(c) << 3);
    endfunction

    assign adv        = !pix_valid_q || bus.pix_ready;
    assign hs         = pix_valid_q && bus.pix_ready;
    assign last_issue = (row == ROW_LAST) && (col == COL_LAST);

    always_comb begin
        row_nxt = row;
        col_nxt = col + COL_ONE;
        if (col == COL_LAST) begin
            col_nxt = '0;
            row_nxt = row + ROW_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bx_q        <= '0;
            by_q        <= '0;
            row         <= '0;
            col         <= '0;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= '0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            pix_row_q   <= '0;
            pix_col_q   <= '0;
            pix_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // An accepted word empties the output register unless a new capture refills it below.
            if (hs) begin
                pix_valid_q <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        bx_q       <= base_x;
                        by_q       <= base_y;
                        row        <= '0;
                        col        <= '0;
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= word_addr(base_y, base_x, '0, '0);
                        busy_q     <= 1'b1;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    if (adv) begin
                        pix_data_q  <= bus.mem_data;
                        pix_row_q   <= row;
                        pix_col_q   <= col;
                        pix_last_q  <= last_issue;
                        pix_valid_q <= 1'b1;
                        row         <= row_nxt;
                        col         <= col_nxt;
                        if (last_issue) begin
                            mem_en_q   <= 1'b0;
                            mem_addr_q <= '0;
                            state      <= DRAIN;
                        end else begin
                            mem_addr_q <= word_addr(by_q, bx_q, row_nxt, col_nxt);
                        end
                    end
                end
                DRAIN: begin
                    if (hs && pix_last_q) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.pix_valid = pix_valid_q;
    assign bus.pix_data  = pix_data_q;
    assign bus.pix_row   = pix_row_q;
    assign bus.pix_col   = pix_col_q;
    assign bus.pix_last  = pix_last_q;
    assign busy          = busy_q;
    assign done          = done_q;
endmodule

// File: tb/tb_ref_win_fetch.sv
// Directed bench for ref_win_fetch: a 32x4 window instance and an 8x1 window
// instance, each reading a memory whose byte i holds i[7:0].
module tb_ref_win_fetch;
    typedef struct {
        logic [31:0] addr;
        int          row;
        int          col;
        bit          last;
    } win_vec_t;

    typedef struct {
        logic [11:0] bx;
        logic [11:0] by;
        logic [31:0] addr;
        logic [63:0] data;
    } single_vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic [11:0] bx_a, by_a, bx_b, by_b;
    logic        busy_a, done_a, busy_b, done_b;
    int          checks = 0;
    int          errors = 0;

    win_vec_t    vec[16];
    single_vec_t svec[4];

    ref_win_fetch_if #(.WIN_W(32), .WIN_H(4)) bus_a ();
    ref_win_fetch_if #(.WIN_W(8),  .WIN_H(1)) bus_b ();

    ref_win_fetch #(.WIN_W(32), .WIN_H(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .base_x(bx_a), .base_y(by_a),
        .busy(busy_a), .done(done_a), .bus(bus_a.master)
    );

    ref_win_fetch #(.WIN_W(8), .WIN_H(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .base_x(bx_b), .base_y(by_b),
        .busy(busy_b), .done(done_b), .bus(bus_b.master)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] word_at(input logic [31:0] a);
        logic [63:0] w;
        logic [31:0] t;
        w = '0;
        for (int b = 0; b < 8; b++) begin
            t = a + 32'(b);
            w[63-8*b -: 8] = t[7:0];
        end
        return w;
    endfunction

    assign bus_a.mem_data = bus_a.mem_en ? word_at(bus_a.mem_addr) : 64'd0;
    assign bus_b.mem_data = bus_b.mem_en ? word_at(bus_b.mem_addr) : 64'd0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int sel, input logic s, input logic [11:0] bx, input logic [11:0] by);
        if (sel == 0) begin
            start_a = s; bx_a = bx; by_a = by;
        end else begin
            start_b = s; bx_b = bx; by_b = by;
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, "_mem_en"},    bus_a.mem_en,    0);
        checkOutput({tag, "_mem_addr"},  bus_a.mem_addr,  0);
        checkOutput({tag, "_pix_valid"}, bus_a.pix_valid, 0);
        checkOutput({tag, "_pix_data"},  bus_a.pix_data,  0);
        checkOutput({tag, "_pix_row"},   bus_a.pix_row,   0);
        checkOutput({tag, "_pix_col"},   bus_a.pix_col,   0);
        checkOutput({tag, "_pix_last"},  bus_a.pix_last,  0);
        checkOutput({tag, "_busy"},      busy_a,          0);
        checkOutput({tag, "_done"},      done_a,          0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          issue, acc;
        bit          exp_done, got_done, prev_stall;
        logic [63:0] prev_data;
        logic [31:0] prev_addr;

        // Window origin (16,2): row r starts at (2+r)*1920+16.
        vec[0]  = '{32'd3856, 0, 0, 1'b0}; vec[1]  = '{32'd3864, 0, 1, 1'b0};
        vec[2]  = '{32'd3872, 0, 2, 1'b0}; vec[3]  = '{32'd3880, 0, 3, 1'b0};
        vec[4]  = '{32'd5776, 1, 0, 1'b0}; vec[5]  = '{32'd5784, 1, 1, 1'b0};
        vec[6]  = '{32'd5792, 1, 2, 1'b0}; vec[7]  = '{32'd5800, 1, 3, 1'b0};
        vec[8]  = '{32'd7696, 2, 0, 1'b0}; vec[9]  = '{32'd7704, 2, 1, 1'b0};
        vec[10] = '{32'd7712, 2, 2, 1'b0}; vec[11] = '{32'd7720, 2, 3, 1'b0};
        vec[12] = '{32'd9616, 3, 0, 1'b0}; vec[13] = '{32'd9624, 3, 1, 1'b0};
        vec[14] = '{32'd9632, 3, 2, 1'b0}; vec[15] = '{32'd9640, 3, 3, 1'b1};

        svec[0] = '{12'd0,    12'd0,    32'd0,       64'h0001020304050607};
        svec[1] = '{12'd1912, 12'd0,    32'd1912,    64'h78797A7B7C7D7E7F};
        svec[2] = '{12'd8,    12'd3,    32'd5768,    64'h88898A8B8C8D8E8F};
        svec[3] = '{12'd0,    12'd4095, 32'd7862400, 64'h8081828384858687};

        // Reset with start held high: reset must win.
        rst = 1'b1;
        applyStimulus(0, 1'b1, 12'd16, 12'd2);
        applyStimulus(1, 1'b0, 12'd0, 12'd0);
        bus_a.pix_ready = 1'b1;
        bus_b.pix_ready = 1'b1;
        tick();
        tick();
        checkIdleZero("reset");
        rst = 1'b0;
        applyStimulus(0, 1'b0, 12'd16, 12'd2);
        tick();
        checkOutput("post_reset_mem_en", bus_a.mem_en, 0);
        checkOutput("post_reset_busy",   busy_a,       0);

        // Full window with ready high; start repeated while busy and on the done cycle,
        // then reset seven cycles into the second window.
        applyStimulus(0, 1'b1, 12'd16, 12'd2);
        tick();
        for (int c = 1; c <= 25; c++) begin
            int s;
            int r;
            applyStimulus(0, 1'b0, 12'd16, 12'd2);
            s = (c >= 19) ? 18 : 0;
            r = c - s;
            checkOutput("mem_en",   bus_a.mem_en,   64'(r >= 1 && r <= 16));
            checkOutput("mem_addr", bus_a.mem_addr, (r >= 1 && r <= 16) ? 64'(vec[r-1].addr) : 64'd0);
            checkOutput("pix_valid", bus_a.pix_valid, 64'(r >= 2 && r <= 17));
            if (r >= 2 && r <= 17) begin
                checkOutput("pix_data", bus_a.pix_data, word_at(vec[r-2].addr));
                checkOutput("pix_row",  bus_a.pix_row,  64'(vec[r-2].row));
                checkOutput("pix_col",  bus_a.pix_col,  64'(vec[r-2].col));
                checkOutput("pix_last", bus_a.pix_last, 64'(vec[r-2].last));
            end
            checkOutput("done", done_a, 64'(r == 18));
            checkOutput("busy", busy_a, 64'(r >= 1 && r <= 17));
            if (c == 5 || c == 18) applyStimulus(0, 1'b1, 12'd16, 12'd2);
            if (c == 25) rst = 1'b1;
            tick();
        end
        rst = 1'b0;
        checkIdleZero("mid_reset");
        for (int k = 0; k < 3; k++) begin
            checkOutput("abort_done",   done_a,       0);
            checkOutput("abort_mem_en", bus_a.mem_en, 0);
            tick();
        end

        // Fresh start with ready toggling 1,0,0: addresses and data must hold across stalls.
        applyStimulus(0, 1'b1, 12'd16, 12'd2);
        tick();
        applyStimulus(0, 1'b0, 12'd16, 12'd2);
        issue = 0; acc = 0; exp_done = 0; got_done = 0; prev_stall = 0;
        prev_data = '0; prev_addr = '0;
        for (int k = 0; k < 200 && !got_done; k++) begin
            bus_a.pix_ready = (k % 3 == 0);
            if (prev_stall) begin
                checkOutput("stall_data", bus_a.pix_data, prev_data);
                checkOutput("stall_addr", bus_a.mem_addr, 64'(prev_addr));
            end
            checkOutput("s_done", done_a, 64'(exp_done));
            if (done_a) got_done = 1;
            exp_done = 0;
            checkOutput("s_mem_en", bus_a.mem_en, 64'(issue < 16));
            if (bus_a.mem_en && issue < 16)
                checkOutput("s_addr", bus_a.mem_addr, 64'(vec[issue].addr));
            if (bus_a.pix_valid && bus_a.pix_ready) begin
                if (acc < 16) begin
                    checkOutput("s_data", bus_a.pix_data, word_at(vec[acc].addr));
                    checkOutput("s_row",  bus_a.pix_row,  64'(vec[acc].row));
                    checkOutput("s_col",  bus_a.pix_col,  64'(vec[acc].col));
                    checkOutput("s_last", bus_a.pix_last, 64'(vec[acc].last));
                end else begin
                    checkOutput("s_extra_word", 64'(acc), 64'd15);
                end
                acc++;
                if (acc == 16) exp_done = 1;
            end
            if (bus_a.mem_en && (!bus_a.pix_valid || bus_a.pix_ready)) issue++;
            prev_stall = bus_a.pix_valid && !bus_a.pix_ready;
            prev_data  = bus_a.pix_data;
            prev_addr  = bus_a.mem_addr;
            if (!got_done) tick();
        end
        checkOutput("s_done_seen", 64'(got_done), 64'd1);
        checkOutput("s_accepted",  64'(acc),      64'd16);
        bus_a.pix_ready = 1'b1;

        // Single-word windows: one access, last on the first word, done three cycles after start.
        tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1'b1, svec[i].bx, svec[i].by);
            tick();
            applyStimulus(1, 1'b0, svec[i].bx, svec[i].by);
            checkOutput("b_mem_en",    bus_b.mem_en,    1);
            checkOutput("b_mem_addr",  bus_b.mem_addr,  64'(svec[i].addr));
            checkOutput("b_busy",      busy_b,          1);
            tick();
            checkOutput("b_pix_valid", bus_b.pix_valid, 1);
            checkOutput("b_pix_data",  bus_b.pix_data,  svec[i].data);
            checkOutput("b_pix_last",  bus_b.pix_last,  1);
            checkOutput("b_pix_rowcol", {bus_b.pix_row, bus_b.pix_col}, 0);
            checkOutput("b_mem_en_off", bus_b.mem_en,   0);
            checkOutput("b_early_done", done_b,         0);
            tick();
            checkOutput("b_done",      done_b,          1);
            checkOutput("b_busy_off",  busy_b,          0);
            checkOutput("b_valid_off", bus_b.pix_valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
